// File: rtl/vote_pkg.sv
// Shared encodings for the vote tally engine: session states and reject codes.
package vote_pkg;

    // Session state; the numeric values are visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Reject reasons reported on rej_code (0 means no reject since clear/reset).
    localparam logic [1:0] REJ_NONE = 2'd0;
    localparam logic [1:0] REJ_CAND = 2'd1;
    localparam logic [1:0] REJ_DUP  = 2'd2;
    localparam logic [1:0] REJ_SAT  = 2'd3;

endpackage

// File: rtl/vote_voter_bitmap.sv
// One "has voted" bit per voter ID. The test port is combinational on the
// current bits, so a set performed at one edge is seen by the next cycle.
module vote_voter_bitmap
    import vote_pkg::*;
#(
    parameter int NUM_VOTERS = 16,
    parameter int VOTER_W    = $clog2(NUM_VOTERS)  // derived, do not override
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [VOTER_W-1:0] vote_voter,
    output logic               voted,
    input  logic               set_en,
    input  logic [VOTER_W-1:0] set_id
);

    logic [NUM_VOTERS-1:0] bits_q;
    logic [NUM_VOTERS-1:0] bits_d;

    // Look up the queried voter; IDs beyond NUM_VOTERS read as not voted.
    always_comb begin
        voted = 1'b0;
        for (int i = 0; i < NUM_VOTERS; i++) begin
            if (vote_voter == VOTER_W'(i)) begin
                voted = bits_q[i];
            end
        end
    end

    // Next bitmap: clear wins over set.
    always_comb begin
        bits_d = bits_q;
        if (clr) begin
            bits_d = '0;
        end else if (set_en) begin
            for (int i = 0; i < NUM_VOTERS; i++) begin
                if (set_id == VOTER_W'(i)) begin
                    bits_d[i] = 1'b1;
                end
            end
        end
    end

    // Bitmap register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/vote_tally_engine.sv
// Session-based vote counter: one vote per voter ID, per-candidate saturating
// check, and a one-candidate-per-cycle max scan that produces winner and tie.
module vote_tally_engine
    import vote_pkg::*;
#(
    parameter int NUM_CAND   = 4,
    parameter int CNT_W      = 8,
    parameter int NUM_VOTERS = 16,
    parameter int CAND_W     = $clog2(NUM_CAND),    // derived, do not override
    parameter int VOTER_W    = $clog2(NUM_VOTERS),  // derived, do not override
    parameter int TOT_W      = CNT_W + CAND_W       // derived, do not override
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_open,
    input  logic               cmd_close,
    input  logic               cmd_clear,
    input  logic               vote_valid,
    output logic               vote_ready,
    input  logic [CAND_W-1:0]  vote_cand,
    input  logic [VOTER_W-1:0] vote_voter,
    output logic               vote_ack,
    output logic               vote_rej,
    output logic [1:0]         rej_code,
    output logic [1:0]         state,
    output logic               result_valid,
    output logic [CAND_W-1:0]  winner,
    output logic [CNT_W-1:0]   winner_count,
    output logic               tie,
    output logic [TOT_W-1:0]   total_votes,
    input  logic [CAND_W-1:0]  rd_idx,
    output logic [CNT_W-1:0]   rd_count
);

    // Handshake: a vote transfers on a cycle where vote_valid && vote_ready.
    // vote_ready is high only in OPEN with no clear (or reset) this cycle, and
    // does not depend on vote_valid. Every transfer gets exactly one response
    // pulse (ack or reject) in the following cycle.

    state_e                           state_q, state_d;
    logic [NUM_CAND-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOT_W-1:0]                 total_q, total_d;
    logic                             ack_q, ack_d;
    logic                             rej_q, rej_d;
    logic [1:0]                       rej_code_q, rej_code_d;
    logic [CAND_W-1:0]                scan_idx_q, scan_idx_d;
    logic [CNT_W-1:0]                 max_q, max_d;
    logic [CAND_W-1:0]                winner_q, winner_d;
    logic                             tie_q, tie_d;
    logic [CNT_W-1:0]                 rd_count_q, rd_count_d;

    logic              xfer;
    logic              cand_bad;
    logic              voted;
    logic              bm_set_en;
    logic              bm_clr;
    logic [CNT_W-1:0]  vote_cnt;
    logic [CNT_W-1:0]  scan_cnt;

    assign vote_ready = (state_q == ST_OPEN) && !cmd_clear && !rst;
    assign xfer       = vote_valid && vote_ready;
    // Widened compare so NUM_CAND == 2**CAND_W never flags a valid index.
    assign cand_bad   = ({1'b0, vote_cand} >= (CAND_W + 1)'(NUM_CAND));

    vote_voter_bitmap #(
        .NUM_VOTERS (NUM_VOTERS)
    ) u_bitmap (
        .clk        (clk),
        .rst        (rst),
        .clr        (bm_clr),
        .vote_voter (vote_voter),
        .voted      (voted),
        .set_en     (bm_set_en),
        .set_id     (vote_voter)
    );

    // Counter selects for the voted candidate and the scanned candidate.
    always_comb begin
        vote_cnt = '0;
        scan_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_cand == CAND_W'(i)) begin
                vote_cnt = cnt_q[i];
            end
            if (scan_idx_q == CAND_W'(i)) begin
                scan_cnt = cnt_q[i];
            end
        end
    end

    // Session FSM, vote checks and scan step; clear overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        total_d    = total_q;
        ack_d      = 1'b0;
        rej_d      = 1'b0;
        rej_code_d = rej_code_q;
        scan_idx_d = scan_idx_q;
        max_d      = max_q;
        winner_d   = winner_q;
        tie_d      = tie_q;
        bm_set_en  = 1'b0;
        bm_clr     = 1'b0;

        if (cmd_clear) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            total_d    = '0;
            rej_code_d = REJ_NONE;
            scan_idx_d = '0;
            max_d      = '0;
            winner_d   = '0;
            tie_d      = 1'b0;
            bm_clr     = 1'b1;
        end else begin
            // A transfer alongside cmd_close still lands before the scan reads cnt_q.
            if (xfer) begin
                if (cand_bad) begin
                    rej_d      = 1'b1;
                    rej_code_d = REJ_CAND;
                end else if (voted) begin
                    rej_d      = 1'b1;
                    rej_code_d = REJ_DUP;
                end else if (vote_cnt == '1) begin
                    rej_d      = 1'b1;
                    rej_code_d = REJ_SAT;
                end else begin
                    ack_d     = 1'b1;
                    bm_set_en = 1'b1;
                    total_d   = total_q + 1'b1;
                    for (int i = 0; i < NUM_CAND; i++) begin
                        if (vote_cand == CAND_W'(i)) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_open) begin
                        state_d = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (cmd_close) begin
                        state_d    = ST_SCAN;
                        scan_idx_d = '0;
                        max_d      = '0;
                        winner_d   = '0;
                        tie_d      = 1'b0;
                    end
                end
                ST_SCAN: begin
                    // Strict '>' keeps the lowest index on ties.
                    if (scan_cnt > max_q) begin
                        max_d    = scan_cnt;
                        winner_d = scan_idx_q;
                        tie_d    = 1'b0;
                    end else if ((scan_cnt == max_q) && (max_q != '0)) begin
                        tie_d = 1'b1;
                    end
                    scan_idx_d = scan_idx_q + 1'b1;
                    if (scan_idx_q == CAND_W'(NUM_CAND - 1)) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Registered counter readback; out-of-range index reads as zero.
    always_comb begin
        rd_count_d = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (rd_idx == CAND_W'(i)) begin
                rd_count_d = cnt_q[i];
            end
        end
    end

    // State, counters, scan and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            total_q    <= '0;
            ack_q      <= 1'b0;
            rej_q      <= 1'b0;
            rej_code_q <= REJ_NONE;
            scan_idx_q <= '0;
            max_q      <= '0;
            winner_q   <= '0;
            tie_q      <= 1'b0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            ack_q      <= ack_d;
            rej_q      <= rej_d;
            rej_code_q <= rej_code_d;
            scan_idx_q <= scan_idx_d;
            max_q      <= max_d;
            winner_q   <= winner_d;
            tie_q      <= tie_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign state        = state_q;
    assign result_valid = (state_q == ST_DONE);
    assign vote_ack     = ack_q;
    assign vote_rej     = rej_q;
    assign rej_code     = rej_code_q;
    assign winner       = winner_q;
    assign winner_count = max_q;
    assign tie          = tie_q;
    assign total_votes  = total_q;
    assign rd_count     = rd_count_q;

endmodule

// File: tb/tb_vote_tally_engine.sv
// Bench for vote_tally_engine built with NUM_CAND=3, CNT_W=2 so that the
// bad-candidate and saturation paths are both reachable.
module tb_vote_tally_engine;

  localparam int NC      = 3;
  localparam int CW      = 2;
  localparam int NV      = 16;
  localparam int CAND_W  = 2;
  localparam int VOTER_W = 4;
  localparam int TOT_W   = CW + CAND_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_open, cmd_close, cmd_clear;
  logic               vote_valid;
  logic               vote_ready;
  logic [CAND_W-1:0]  vote_cand;
  logic [VOTER_W-1:0] vote_voter;
  logic               vote_ack, vote_rej;
  logic [1:0]         rej_code;
  logic [1:0]         state;
  logic               result_valid;
  logic [CAND_W-1:0]  winner;
  logic [CW-1:0]      winner_count;
  logic               tie;
  logic [TOT_W-1:0]   total_votes;
  logic [CAND_W-1:0]  rd_idx;
  logic [CW-1:0]      rd_count;

  vote_tally_engine #(
    .NUM_CAND   (NC),
    .CNT_W      (CW),
    .NUM_VOTERS (NV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_open     (cmd_open),
    .cmd_close    (cmd_close),
    .cmd_clear    (cmd_clear),
    .vote_valid   (vote_valid),
    .vote_ready   (vote_ready),
    .vote_cand    (vote_cand),
    .vote_voter   (vote_voter),
    .vote_ack     (vote_ack),
    .vote_rej     (vote_rej),
    .rej_code     (rej_code),
    .state        (state),
    .result_valid (result_valid),
    .winner       (winner),
    .winner_count (winner_count),
    .tie          (tie),
    .total_votes  (total_votes),
    .rd_idx       (rd_idx),
    .rd_count     (rd_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected response {ack, rej, rej_code} per vote transfer.
  logic [3:0] exp_q[$];

  // Reference model of the tally.
  int         m_cnt[NC];
  bit         m_voted[NV];
  int         m_tot;
  logic [1:0] m_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    for (int i = 0; i < NV; i++) m_voted[i] = 1'b0;
    m_tot  = 0;
    m_code = 2'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_open();
    cmd_open = 1'b1;
    step();
    cmd_open = 1'b0;
  endtask

  task automatic do_clear();
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    model_clear();
  endtask

  task automatic send_vote(input int cand, input int voter, input bit with_close);
    logic [3:0] e;
    if (cand >= NC) begin
      m_code = 2'd1;
      e = {2'b01, 2'd1};
    end else if (m_voted[voter]) begin
      m_code = 2'd2;
      e = {2'b01, 2'd2};
    end else if (m_cnt[cand] == (1 << CW) - 1) begin
      m_code = 2'd3;
      e = {2'b01, 2'd3};
    end else begin
      m_cnt[cand]++;
      m_voted[voter] = 1'b1;
      m_tot++;
      e = {2'b10, m_code};
    end
    exp_q.push_back(e);
    vote_valid = 1'b1;
    vote_cand  = CAND_W'(cand);
    vote_voter = VOTER_W'(voter);
    cmd_close  = with_close;
    step();
    vote_valid = 1'b0;
    cmd_close  = 1'b0;
  endtask

  task automatic read_cnt(input int idx, input int exp, input string tag);
    rd_idx = CAND_W'(idx);
    step();
    check(tag, 32'(rd_count), 32'(exp));
  endtask

  // Waits (bounded) for result_valid and compares the scan result with the model.
  task automatic wait_and_check_result(input string tag);
    int cycles;
    int mx, w, nmax;
    cycles = 0;
    while (!result_valid && cycles < 20) begin
      step();
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(NC));
    mx = 0;
    for (int i = 0; i < NC; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
    w = 0;
    for (int i = NC - 1; i >= 0; i--) if (m_cnt[i] == mx) w = i;
    nmax = 0;
    for (int i = 0; i < NC; i++) if (m_cnt[i] == mx) nmax++;
    check({tag, "_winner"}, 32'(winner), 32'(w));
    check({tag, "_count"},  32'(winner_count), 32'(mx));
    check({tag, "_tie"},    32'(tie), 32'((mx > 0) && (nmax > 1)));
    check({tag, "_total"},  32'(total_votes), 32'(m_tot));
  endtask

  task automatic do_close_and_check(input string tag);
    cmd_close = 1'b1;
    step();
    cmd_close = 1'b0;
    check({tag, "_scan_state"}, 32'(state), 32'd2);
    wait_and_check_result(tag);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (vote_ack || vote_rej) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {28'd0, vote_ack, vote_rej, rej_code}, 32'd0);
      end else begin
        check("vote_resp", {28'd0, vote_ack, vote_rej, rej_code}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    rst = 1'b1;
    cmd_open = 1'b0; cmd_close = 1'b0; cmd_clear = 1'b0;
    vote_valid = 1'b0; vote_cand = '0; vote_voter = '0; rd_idx = '0;
    model_clear();
    step();
    step();
    rst = 1'b0;

    // Reset values.
    check("rst_state", 32'(state), 32'd0);
    check("rst_outputs",
          {vote_ready, vote_ack, vote_rej, rej_code, result_valid, winner, winner_count, tie,
           total_votes, rd_count}, 32'd0);

    // close in IDLE is ignored.
    cmd_close = 1'b1;
    step();
    cmd_close = 1'b0;
    check("idle_close_ignored", 32'(state), 32'd0);

    // Main tally: three votes for cand 2, one for cand 1.
    do_open();
    check("open_state", 32'(state), 32'd1);
    check("open_ready", 32'(vote_ready), 32'd1);
    send_vote(2, 0, 1'b0);
    send_vote(2, 1, 1'b0);
    send_vote(2, 2, 1'b0);
    send_vote(1, 3, 1'b0);
    read_cnt(2, 3, "a_cnt2");
    do_close_and_check("a");
    cmd_open = 1'b1;
    step();
    cmd_open = 1'b0;
    check("done_open_ignored", 32'(state), 32'd3);
    read_cnt(1, 1, "a_cnt1");
    read_cnt(3, 0, "rd_out_of_range");

    // Clear zeroes everything.
    do_clear();
    check("clr_state", 32'(state), 32'd0);
    check("clr_total", 32'(total_votes), 32'd0);
    read_cnt(2, 0, "clr_cnt2");

    // Duplicate, bad-candidate and saturation rejects in one session.
    do_open();
    send_vote(0, 5, 1'b0);
    send_vote(1, 5, 1'b0);
    check("dup_code", 32'(rej_code), 32'd2);
    read_cnt(1, 0, "dup_cnt1");
    check("dup_total", 32'(total_votes), 32'd1);
    send_vote(3, 7, 1'b0);
    check("bad_code", 32'(rej_code), 32'd1);
    check("bad_total", 32'(total_votes), 32'd1);
    send_vote(0, 7, 1'b0);
    send_vote(1, 0, 1'b0);
    send_vote(1, 1, 1'b0);
    send_vote(1, 2, 1'b0);
    send_vote(1, 3, 1'b0);
    check("sat_code", 32'(rej_code), 32'd3);
    read_cnt(1, 3, "sat_cnt1");
    send_vote(0, 3, 1'b0);
    read_cnt(0, 3, "sat_cnt0");
    do_close_and_check("b");

    // Tie: two each for cand 1 and cand 2, last vote arrives with close.
    do_clear();
    do_open();
    send_vote(1, 0, 1'b0);
    send_vote(2, 1, 1'b0);
    send_vote(1, 2, 1'b0);
    send_vote(2, 3, 1'b1);
    check("tie_close_state", 32'(state), 32'd2);
    wait_and_check_result("tie");
    check("tie_winner_fixed", 32'(winner), 32'd1);
    check("tie_flag_fixed", 32'(tie), 32'd1);

    // No votes cast.
    do_clear();
    do_open();
    do_close_and_check("empty");

    // Random session.
    do_clear();
    do_open();
    for (int k = 0; k < 14; k++) begin
      send_vote($urandom_range(0, 3), $urandom_range(0, NV - 1), 1'b0);
    end
    for (int i = 0; i < NC; i++) read_cnt(i, m_cnt[i], "rnd_cnt");
    do_close_and_check("rnd");

    // Clear during the second scan cycle aborts the scan.
    do_clear();
    do_open();
    send_vote(0, 0, 1'b0);
    cmd_close = 1'b1;
    step();
    cmd_close = 1'b0;
    step();
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    model_clear();
    check("abort_state", 32'(state), 32'd0);
    check("abort_total", 32'(total_votes), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < NC + 3; k++) begin
      seen |= result_valid;
      step();
    end
    check("abort_no_result", 32'(seen), 32'd0);

    // Reset in OPEN with a vote offered: no response, everything zero.
    do_open();
    send_vote(3, 4, 1'b0);
    send_vote(2, 4, 1'b0);
    rd_idx = 2'd2;
    step();
    check("pre_rst_rd", 32'(rd_count), 32'd1);
    vote_valid = 1'b1;
    vote_cand  = 2'd0;
    vote_voter = 4'd9;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vote_valid = 1'b0;
    model_clear();
    check("rst_open_state", 32'(state), 32'd0);
    check("rst_open_outputs",
          {vote_ready, vote_ack, vote_rej, rej_code, result_valid, winner, winner_count, tie,
           total_votes, rd_count}, 32'd0);

    step();
    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vote_tally_engine.md
# vote_tally_engine

Parametrised successor to the 4-candidate TinyTapeout voting machine. It counts votes for `NUM_CAND` candidates in binary-indexed form and enforces one vote per voter ID. Voting runs as an explicit session (open / close / clear). On close, a sequential max-scan produces the winner, the tie flag and the totals. The block sits behind the pin-level wrapper, which maps `ui_in`/`uo_out` onto these ports.

## Interface
Parameters:
- `NUM_CAND`, 4: number of candidates, ≥2; `CAND_W = $clog2(NUM_CAND)`.
- `CNT_W`, 8: per-candidate counter width.
- `NUM_VOTERS`, 16: number of distinct voter IDs; `VOTER_W = $clog2(NUM_VOTERS)`.
- Derived `TOT_W = CNT_W + CAND_W`.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_open`, `cmd_close`, `cmd_clear` in 1 each: session command pulses, sampled every cycle.
- `vote_valid` in 1, `vote_ready` out 1: vote handshake.
- `vote_cand` in CAND_W: candidate index.
- `vote_voter` in VOTER_W: voter ID.
- `vote_ack` out 1: one-cycle pulse, vote counted.
- `vote_rej` out 1: one-cycle pulse, vote rejected.
- `rej_code` out 2: reject reason; 1 = bad candidate, 2 = duplicate voter, 3 = counter saturated. Holds its value until the next reject.
- `state` out 2: 0 = IDLE, 1 = OPEN, 2 = SCAN, 3 = DONE.
- `result_valid` out 1: high only in DONE.
- `winner` out CAND_W, `winner_count` out CNT_W, `tie` out 1: scan result.
- `total_votes` out TOT_W: number of accepted votes.
- `rd_idx` in CAND_W, `rd_count` out CNT_W: registered counter readback.

## Operation
- Reset: every output is 0, state is IDLE, all counters, the voter bitmap and the scan registers are 0.
- Command priority: `rst` > `cmd_clear` > `cmd_close` > `cmd_open`.
- `cmd_clear` from any state:
  - Next state is IDLE.
  - Counters, the voter bitmap, `total_votes`, the result registers and `rej_code` are zeroed.
  - An in-flight vote handshake in the same cycle is dropped, with no ack or reject.
- IDLE→OPEN on `cmd_open`. `cmd_open` is ignored in OPEN, SCAN and DONE.
- OPEN→SCAN on `cmd_close`. `cmd_close` is ignored in every other state.
- SCAN→DONE automatically after `NUM_CAND` cycles. DONE is held until `cmd_clear`.
- `vote_ready` = (state == OPEN) and no `cmd_clear` this cycle. A transfer happens when `vote_valid & vote_ready`.
- Checks on a transfer, evaluated in this order:
  - `vote_cand ≥ NUM_CAND` → reject with code 1.
  - Voter bit already set → reject with code 2.
  - Target counter equals all-ones → reject with code 3.
  - Otherwise: counter +1, voter bit set, `total_votes` +1, ack.
- A rejected vote never sets the voter bit.
- A transfer in the same cycle as `cmd_close` is fully processed and counted before the scan.
- Scan, for i = 0..NUM_CAND-1, one candidate per cycle; `max` and `tie` start at 0:
  - `cnt[i] > max`: max = cnt[i], winner = i, tie = 0.
  - `cnt[i] == max` with max > 0: tie = 1.
  - Ties report the lowest index as `winner`.
- No votes cast: `winner` = 0, `winner_count` = 0, `tie` = 0.
- `rd_count` returns `cnt[rd_idx]` in any state; an out-of-range `rd_idx` returns 0.

## Timing
- Vote accepted at edge t → `vote_ack`/`vote_rej` high during cycle t+1 only, and the counter and `total_votes` show the update from t+1.
- Back-to-back transfers every cycle are legal. A duplicate ID in consecutive cycles must be rejected, so the bitmap update is visible to the very next transfer.
- `cmd_close` at t → state = SCAN at t+1 → `result_valid` rises at t+1+NUM_CAND.
- `rd_count` latency is 1 cycle.
- `rst` or `cmd_clear` mid-scan aborts the scan; `result_valid` stays 0.

## Structure
- Package `vote_pkg` holds:
  - the state encoding constants (`ST_IDLE`, `ST_OPEN`, `ST_SCAN`, `ST_DONE`);
  - the reject codes (`REJ_CAND`, `REJ_DUP`, `REJ_SAT`).
- Sub-module `vote_voter_bitmap` (NUM_VOTERS bits):
  - test port: `vote_voter` → "voted" flag;
  - set port: `set_en`, `set_id`;
  - sync clear.
- Counters, FSM and scan stay in the top module.

## Test plan
- NUM_CAND=4: open; voters 0,1,2 vote cand 2 and voter 3 votes cand 1; close → after 4 SCAN cycles, `winner`=2, `winner_count`=3, `tie`=0, `total_votes`=4.
- Voter 5 votes cand 0, then voter 5 votes cand 1 on the next cycle → first ack, second reject with `rej_code`=2; `cnt[1]`=0, `total_votes`=1.
- `vote_cand`=3 with NUM_CAND=3 → reject with code 1, no counter change, and that voter can then vote cand 0 with an ack.
- CNT_W=2: voters 0–2 vote cand 1, then voter 3 votes cand 1 → reject with code 3, `cnt[1]`=3, and voter 3 can then vote cand 0 with an ack.
- Two votes each for cand 1 and cand 3 → `winner`=1, `tie`=1; close with no votes → `winner`=0, `winner_count`=0, `tie`=0.
- Assert `cmd_clear` during the 2nd SCAN cycle → state IDLE, all counts 0, `result_valid` never rises. Assert `rst` with `vote_valid` high in OPEN → no ack or reject, all outputs 0 on the next cycle.
